// File: rtl/result_bcd_conv.sv
// rtl/result_bcd_conv.sv - sequential double-dabble binary-to-BCD converter for the adder result.
// Optional leading-zero blanking is enabled with `define BCD_LEADING_ZERO_BLANK_EN.
module result_bcd_conv #(
    parameter int IN_WIDTH = 9,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  busy,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_blank
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]        scr_q, scr_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic [BW-1:0]        scr_adj, scr_shift;
    logic [IN_WIDTH-1:0]  bin_shift;
    logic                 last_shift;

    // Add-3 correction precedes the shift; a digit <= 9 plus 3 never exceeds 4 bits.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        {scr_shift, bin_shift} = {scr_adj, bin_q} << 1;
        last_shift = (cnt_q == CNT_W'(IN_WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE, DONE: begin
                if (in_valid) begin
                    bin_d   = in_data;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                scr_d = scr_shift;
                bin_d = bin_shift;
                cnt_d = cnt_q + 1'b1;
                if (last_shift) begin
                    bcd_d   = scr_shift;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign bcd       = bcd_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              higher_zero;

    // Ones digit is never blanked so that zero still displays as "0".
    always_comb begin
        blank_d     = blank_q;
        higher_zero = 1'b1;
        if (state_q == SHIFT && last_shift) begin
            blank_d = '0;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                higher_zero = higher_zero & (scr_shift[4*i +: 4] == 4'd0);
                blank_d[i]  = higher_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign digit_blank = blank_q;
`else
    assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_result_bcd_conv.sv
// tb/tb_result_bcd_conv.sv - self-checking bench for result_bcd_conv against a countdown/arithmetic model.
module tb_result_bcd_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [8:0]  in_data = '0;
    logic        busy;
    logic        out_valid;
    logic [11:0] bcd;
    logic [2:0]  digit_blank;

    int n_vec = 0;
    int n_err = 0;

    result_bcd_conv #(.IN_WIDTH(9), .DIGITS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .busy        (busy),
        .out_valid   (out_valid),
        .bcd         (bcd),
        .digit_blank (digit_blank)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [2:0] to_blank(input int v);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        logic [2:0] b;
        b    = 3'b000;
        b[2] = (v / 100) == 0;
        b[1] = (v / 10) == 0;
        return b;
`else
        return 3'b000 & 3'(v);
`endif
    endfunction

    // Model: a conversion is a 9-edge countdown after capture; result appears when it expires.
    int          m_rem = 0;
    int          m_pend = 0;
    logic        m_valid = 1'b0;
    logic [11:0] m_bcd = '0;
    logic [2:0]  m_blank = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rem   = 0;
            m_valid = 1'b0;
            m_bcd   = '0;
            m_blank = '0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_valid = 1'b1;
                m_bcd   = to_bcd(m_pend);
                m_blank = to_blank(m_pend);
            end
        end else begin
            m_valid = 1'b0;
            if (in_valid) begin
                m_pend = int'(in_data);
                m_rem  = 9;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_rem > 0));
        check("out_valid", int'(out_valid), int'(m_valid));
        check("bcd", int'(bcd), int'(m_bcd));
        check("digit_blank", int'(digit_blank), int'(m_blank));
    end

    int ov_count = 0;
    always @(posedge clk) if (out_valid) ov_count++;

    // Drive a capture at the current negedge and wait for out_valid; n counts negedges.
    task automatic convert(input int v, output int n, output int busy_n);
        in_valid = 1'b1;
        in_data  = 9'(v);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 9'h1AA;
        n = 1;
        busy_n = int'(busy);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
            busy_n += int'(busy);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, bn, ov0;
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_bcd", int'(bcd), 0);
        check("rst_blank", int'(digit_blank), 0);
        rst = 1'b1;
        @(negedge clk);

        convert(256, n, bn);
        check("lat_256_edges", n - 1, 9);
        check("busy_cycles_256", bn, 9);
        check("bcd_256", int'(bcd), 'h256);
        @(negedge clk);
        check("ov_single_pulse", int'(out_valid), 0);

        convert(0, n, bn);
        check("bcd_0", int'(bcd), 'h000);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check("blank_0", int'(digit_blank), 'b110);
`else
        check("blank_0", int'(digit_blank), 'b000);
`endif
        @(negedge clk);

        convert(511, n, bn);
        check("bcd_511", int'(bcd), 'h511);
        check("blank_511", int'(digit_blank), 0);
        @(negedge clk);
        convert(9, n, bn);
        check("bcd_9", int'(bcd), 'h009);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check("blank_9", int'(digit_blank), 'b110);
`else
        check("blank_9", int'(digit_blank), 'b000);
`endif
        @(negedge clk);

        // in_valid while busy must be dropped
        ov0 = ov_count;
        in_valid = 1'b1;
        in_data  = 9'd37;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 9'd100;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(n);
        check("bcd_37_busy_drop", int'(bcd), 'h037);
        repeat (20) @(negedge clk);
        check("ov_count_busy_drop", ov_count - ov0, 1);

        // back-to-back: capture in the DONE cycle
        convert(45, n, bn);
        check("bcd_45", int'(bcd), 'h045);
        convert(200, n, bn);
        check("b2b_gap_cycles", n, 10);
        check("bcd_200", int'(bcd), 'h200);
        @(negedge clk);

        // asynchronous reset mid-shift
        ov0 = ov_count;
        in_valid = 1'b1;
        in_data  = 9'd77;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("amid_busy", int'(busy), 0);
        check("amid_out_valid", int'(out_valid), 0);
        check("amid_bcd", int'(bcd), 0);
        check("amid_blank", int'(digit_blank), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("no_ov_after_abort", ov_count - ov0, 0);
        convert(128, n, bn);
        check("lat_128_edges", n - 1, 9);
        check("bcd_128", int'(bcd), 'h128);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
